// File: rtl/sub16_borrow_skip_pipe.sv
// Four-stage pipelined 16-bit borrow-skip subtractor: diff = a - b - bin.
// One 4-bit borrow-skip block per stage, with a global valid/ready stall.
module sub16_borrow_skip_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned W  = 16;
  localparam int unsigned BW = 4;

  // 4-bit block: ripple borrow for the diff bits, skip mux for the block borrow-out.
  function automatic logic [BW:0] blk(input logic [BW-1:0] x, input logic [BW-1:0] y,
                                      input logic bi);
    logic [BW:0]   br;
    logic [BW-1:0] p;
    logic [BW-1:0] g;
    logic [BW-1:0] d;
    br[0] = bi;
    for (int i = 0; i < int'(BW); i++) begin
      p[i]    = ~(x[i] ^ y[i]);
      g[i]    = ~x[i] & y[i];
      d[i]    = x[i] ^ y[i] ^ br[i];
      br[i+1] = g[i] | (p[i] & br[i]);
    end
    return {((&p) ? bi : br[BW]), d};
  endfunction

  logic              adv;
  logic [BW:0]       r0, r1, r2, r3;
  logic              ovf_nx;

  logic              s0_v, s0_br, s0_a15, s0_b15;
  logic [BW-1:0]     s0_d;
  logic [W-1:BW]     s0_a, s0_b;

  logic              s1_v, s1_br, s1_a15, s1_b15;
  logic [2*BW-1:0]   s1_d;
  logic [W-1:2*BW]   s1_a, s1_b;

  logic              s2_v, s2_br, s2_a15, s2_b15;
  logic [3*BW-1:0]   s2_d;
  logic [W-1:3*BW]   s2_a, s2_b;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign r0 = blk(a[BW-1:0], b[BW-1:0], bin);
  assign r1 = blk(s0_a[2*BW-1:BW], s0_b[2*BW-1:BW], s0_br);
  assign r2 = blk(s1_a[3*BW-1:2*BW], s1_b[3*BW-1:2*BW], s1_br);
  assign r3 = blk(s2_a[W-1:3*BW], s2_b[W-1:3*BW], s2_br);

  assign ovf_nx = (s2_a15 != s2_b15) && (r3[BW-1] != s2_a15);

  // Pipeline registers: whole pipe shifts together on adv, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v <= 1'b0; s0_br <= 1'b0; s0_a15 <= 1'b0; s0_b15 <= 1'b0;
      s0_d <= '0;   s0_a <= '0;    s0_b <= '0;
      s1_v <= 1'b0; s1_br <= 1'b0; s1_a15 <= 1'b0; s1_b15 <= 1'b0;
      s1_d <= '0;   s1_a <= '0;    s1_b <= '0;
      s2_v <= 1'b0; s2_br <= 1'b0; s2_a15 <= 1'b0; s2_b15 <= 1'b0;
      s2_d <= '0;   s2_a <= '0;    s2_b <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      s0_v <= in_valid;
      // Operands are sampled only on an accepting edge.
      if (in_valid) begin
        s0_d   <= r0[BW-1:0];
        s0_br  <= r0[BW];
        s0_a   <= a[W-1:BW];
        s0_b   <= b[W-1:BW];
        s0_a15 <= a[W-1];
        s0_b15 <= b[W-1];
      end

      s1_v   <= s0_v;
      s1_d   <= {r1[BW-1:0], s0_d};
      s1_br  <= r1[BW];
      s1_a   <= s0_a[W-1:2*BW];
      s1_b   <= s0_b[W-1:2*BW];
      s1_a15 <= s0_a15;
      s1_b15 <= s0_b15;

      s2_v   <= s1_v;
      s2_d   <= {r2[BW-1:0], s1_d};
      s2_br  <= r2[BW];
      s2_a   <= s1_a[W-1:3*BW];
      s2_b   <= s1_b[W-1:3*BW];
      s2_a15 <= s1_a15;
      s2_b15 <= s1_b15;

      out_valid <= s2_v;
      diff      <= {r3[BW-1:0], s2_d};
      bout      <= r3[BW];
      ovf       <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_sub16_borrow_skip_pipe.sv
// Scoreboard bench for sub16_borrow_skip_pipe: directed boundaries,
// backpressure, mid-flight reset and a random regression.
module tb_sub16_borrow_skip_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        bin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, bout, ovf, out_valid;
  logic [15:0] diff;

  sub16_borrow_skip_pipe dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready), .diff(diff), .bout(bout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0, n_err = 0, cyc = 0;
  logic        lat_on = 1'b0, prev_stall = 1'b0;
  logic [15:0] hold_diff;
  logic [1:0]  hold_flags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t        r;
    logic [16:0] f;
    f    = {1'b0, x} - {1'b0, y} - 17'(c);
    r.d  = f[15:0];
    r.bo = f[16];
    r.ov = (x[15] != y[15]) && (f[15] != x[15]);
    r.cyc = 0;
    return r;
  endfunction

  // One cycle: drive at negedge, check output handshake, record accepted op.
  task automatic step(input logic iv, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tbin, input logic ordy, input logic use_ex,
                      input exp_t ex, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = ta; b = tb_; bin = tbin; out_ready = ordy;
    #1;
    cyc++;
    if (prev_stall) begin
      chk("hold_diff", 32'(diff), 32'(hold_diff));
      chk("hold_flags", 32'({bout, ovf}), 32'(hold_flags));
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("extra_out", 32'(out_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("bout", 32'(bout), 32'(e.bo));
        chk("ovf", 32'(ovf), 32'(e.ov));
        if (lat_on) chk("latency", 32'(cyc - e.cyc), 32'd4);
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      e = use_ex ? ex : model(ta, tb_, tbin);
      e.cyc = cyc;
      sbq.push_back(e);
    end
    prev_stall = out_valid && !out_ready;
    hold_diff  = diff;
    hold_flags = {bout, ovf};
  endtask

  task automatic drain();
    logic acc;
    exp_t z;
    z = '{default: 0};
    for (int i = 0; i < 50 && sbq.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, z, acc);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  logic [15:0] ta_t[8] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h5A5A, 16'hA5A5};
  logic [15:0] tb_t[8] = '{16'h0034, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h5A5A, 16'h5A5A};
  logic        tc_t[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [15:0] td_t[8] = '{16'h1200, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h4B4B};
  logic        tbo_t[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        tov_t[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic acc;
    exp_t ex;
    int   idx, nacc, ncyc;
    logic [15:0] i16;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({bout, ovf}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Directed boundary cases, back-to-back, no stall.
    lat_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ex = '{d: td_t[i], bo: tbo_t[i], ov: tov_t[i], cyc: 0};
      step(1'b1, ta_t[i], tb_t[i], tc_t[i], 1'b1, 1'b1, ex, acc);
      chk("dir_accept", 32'(acc), 32'd1);
    end
    drain();

    // Eight ops with out_ready low for cycles 5..9.
    lat_on = 1'b0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      i16 = 16'(idx);
      step(idx < 8, i16 * 16'h1111, i16, i16[0], !(c >= 5 && c <= 9), 1'b0, ex, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd8);
    drain();

    // Reset with three ops in flight.
    lat_on = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 * 16'(i + 1), 16'h0003, 1'b1, 1'b1, 1'b0, ex, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_flags", 32'({bout, ovf}), 32'd0);
    sbq.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, ex, acc);
    step(1'b1, 16'h4321, 16'h1111, 1'b0, 1'b1, 1'b0, ex, acc);
    drain();

    // Random regression against the reference model.
    lat_on = 1'b0;
    nacc = 0;
    ncyc = 0;
    while (nacc < 10000 && ncyc < 60000) begin
      step($urandom_range(99) < 65, 16'($urandom), 16'($urandom), 1'($urandom),
           $urandom_range(99) < 70, 1'b0, ex, acc);
      if (acc) nacc++;
      ncyc++;
    end
    chk("rand_accepted", 32'(nacc), 32'd10000);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
